// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns EX/MEM load/store into a valid/ready request
// to a multi-cycle data memory, stalls the pipeline until done, aborts on timeout.
module mem_access_unit #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            MemWriteM,
  input  logic            MemToRegM,
  input  logic [SIZE-1:0] ALUOutM,
  input  logic [SIZE-1:0] WriteDataM,
  output logic            StallM,
  output logic [SIZE-1:0] ReadDataM,
  output logic            MemErrM,
  output logic            MemReqValid,
  input  logic            MemReqReady,
  output logic            MemReqWe,
  output logic [SIZE-1:0] MemReqAddr,
  output logic [SIZE-1:0] MemReqWData,
  input  logic            MemRspValid,
  input  logic [SIZE-1:0] MemRspRData
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic              err_reg;
  logic [SIZE-1:0]   addr_reg;
  logic [SIZE-1:0]   wdata_reg;
  logic [SIZE-1:0]   rdata_reg;

  logic              access_present;
  logic              handshake;
  logic              rsp_hit;
  logic              expired;
  logic              abort;
  logic              stall_comb;
  logic              unused_addr_bits;

  assign access_present   = MemWriteM | MemToRegM;
  assign handshake        = (state_reg == REQ) && MemReqReady;
  assign rsp_hit          = (state_reg == WAIT_RSP) && MemRspValid;
  assign expired          = (cnt_reg >= CNT_LAST);
  // Completion in the final allowed cycle wins over the abort.
  assign abort            = expired &&
                            (((state_reg == REQ) && !MemReqReady) ||
                             ((state_reg == WAIT_RSP) && !MemRspValid));
  assign unused_addr_bits = ^ALUOutM[1:0];

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (access_present) state_next = REQ;
      end
      REQ: begin
        if (handshake)  state_next = we_reg ? DONE : WAIT_RSP;
        else if (abort) state_next = DONE;
      end
      WAIT_RSP: begin
        if (rsp_hit || abort) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, timeout counter, error flag and load result
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access_present) begin
            we_reg    <= MemWriteM;
            addr_reg  <= {ALUOutM[SIZE-1:2], 2'b00};
            wdata_reg <= WriteDataM;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
          end
        end
        REQ, WAIT_RSP: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (rsp_hit) begin
            rdata_reg <= MemRspRData;
          end else if (abort) begin
            err_reg <= 1'b1;
            if (!we_reg) rdata_reg <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall_comb  = 1'b0;
    MemReqValid = 1'b0;
    MemErrM     = 1'b0;
    case (state_reg)
      IDLE:     stall_comb = access_present;
      REQ: begin
        stall_comb  = 1'b1;
        MemReqValid = 1'b1;
      end
      WAIT_RSP: stall_comb = 1'b1;
      DONE:     MemErrM = err_reg;
      default: begin
      end
    endcase
  end

  // Reset releases the pipeline in the same cycle it is asserted.
  assign StallM      = stall_comb & RST_N;
  assign ReadDataM   = rdata_reg;
  assign MemReqWe    = we_reg;
  assign MemReqAddr  = addr_reg;
  assign MemReqWData = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a cycle-level memory responder.
module tb_mem_access_unit;

  logic        CLK;
  logic        RST_N;
  logic        MemWriteM;
  logic        MemToRegM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MemErrM;
  logic        MemReqValid;
  logic        MemReqReady;
  logic        MemReqWe;
  logic [31:0] MemReqAddr;
  logic [31:0] MemReqWData;
  logic        MemRspValid;
  logic [31:0] MemRspRData;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.SIZE(32), .TIMEOUT(8)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .MemWriteM   (MemWriteM),
    .MemToRegM   (MemToRegM),
    .ALUOutM     (ALUOutM),
    .WriteDataM  (WriteDataM),
    .StallM      (StallM),
    .ReadDataM   (ReadDataM),
    .MemErrM     (MemErrM),
    .MemReqValid (MemReqValid),
    .MemReqReady (MemReqReady),
    .MemReqWe    (MemReqWe),
    .MemReqAddr  (MemReqAddr),
    .MemReqWData (MemReqWData),
    .MemRspValid (MemRspValid),
    .MemRspRData (MemRspRData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp_data;
    int          ready_delay;
    logic        respond;
    logic        exp_we;
    logic [31:0] exp_addr;
    int          exp_stall;
    int          exp_hs;
    int          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0;
    int stall_cnt = 0;
    int hs_cnt = 0;
    int req_cyc = 0;
    int err_cnt = 0;
    bit rsp_pending = 0;
    bit done = 0;
    MemWriteM  = v.we;
    MemToRegM  = v.rd;
    ALUOutM    = v.addr;
    WriteDataM = v.wdata;
    while (!done && cyc < 40) begin
      MemReqReady = (req_cyc >= v.ready_delay);
      MemRspValid = rsp_pending && v.respond;
      MemRspRData = v.rsp_data;
      #1;
      if (MemErrM) err_cnt++;
      if (MemReqValid) begin
        check("req_addr", MemReqAddr, v.exp_addr);
        check("req_we", MemReqWe, v.exp_we);
        check("req_wdata", MemReqWData, v.wdata);
        req_cyc++;
        if (MemReqReady) hs_cnt++;
      end
      rsp_pending = MemReqValid && MemReqReady && !MemReqWe;
      if (!StallM) begin
        done = 1;
        check("done_valid", MemReqValid, 1'b0);
        check("done_rdata", ReadDataM, v.exp_rdata);
      end else begin
        stall_cnt++;
      end
      @(negedge CLK);
      cyc++;
    end
    if (!done) begin
      errors++;
      $display("FAIL vec%0d_no_done: got stall after %0d cycles expected release", idx, cyc);
    end
    check("stall_cycles", stall_cnt, v.exp_stall);
    check("handshakes", hs_cnt, v.exp_hs);
    check("err_pulses", err_cnt, v.exp_err);
    $display("vec %0d: we=%0b rd=%0b addr=%h stall=%0d hs=%0d err=%0d rdata=%h",
             idx, v.we, v.rd, v.addr, stall_cnt, hs_cnt, err_cnt, ReadDataM);
    MemWriteM   = 1'b0;
    MemToRegM   = 1'b0;
    MemReqReady = 1'b0;
    MemRspValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t extra;
    //          we    rd    addr          wdata         rsp           dly resp  eWe   eAddr         st hs er eRdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0000_0000, 32'hDEAD_BEEF, 0,  1'b1, 1'b0, 32'h0000_0104, 3, 1, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 4,  1'b0, 1'b1, 32'h0000_0020, 6, 1, 0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0047, 32'hA5A5_A5A5, 32'h1111_1111, 0,  1'b1, 1'b1, 32'h0000_0044, 2, 1, 0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0203, 32'hFFFF_0000, 32'hCAFE_F00D, 1,  1'b1, 1'b0, 32'h0000_0200, 4, 1, 0, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0BAD_F00D, 32'h0000_0000, 0,  1'b0, 1'b1, 32'h0000_0040, 2, 1, 0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0080, 32'h7777_7777, 32'h0000_0000, 99, 1'b0, 1'b1, 32'h0000_0080, 9, 0, 1, 32'hCAFE_F00D};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0000_0000, 32'h0000_0000, 0,  1'b0, 1'b0, 32'h0000_0104, 9, 1, 1, 32'h0000_0000};

    RST_N       = 1'b0;
    MemWriteM   = 1'b0;
    MemToRegM   = 1'b0;
    ALUOutM     = '0;
    WriteDataM  = '0;
    MemReqReady = 1'b0;
    MemRspValid = 1'b0;
    MemRspRData = '0;
    #1;
    check("rst_stall", StallM, 1'b0);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_err", MemErrM, 1'b0);
    check("rst_valid", MemReqValid, 1'b0);
    check("rst_we", MemReqWe, 1'b0);
    check("rst_addr", MemReqAddr, 32'h0);
    check("rst_wdata", MemReqWData, 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // All vectors run back to back with no idle bubble between them.
    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Late response after the timed-out load must be ignored.
    MemRspValid = 1'b1;
    MemRspRData = 32'h55AA_55AA;
    #1;
    check("late_stall", StallM, 1'b0);
    @(negedge CLK);
    MemRspValid = 1'b0;
    #1;
    check("late_rdata", ReadDataM, 32'h0);
    check("late_err", MemErrM, 1'b0);
    $display("late response: rdata=%h", ReadDataM);
    @(negedge CLK);

    extra = '{1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h1357_9BDF, 0, 1'b1, 1'b0, 32'h0000_0010, 3, 1, 0, 32'h1357_9BDF};
    run_vec(7, extra);

    // Reset asserted while waiting for a read response.
    MemToRegM   = 1'b1;
    ALUOutM     = 32'h0000_0300;
    MemReqReady = 1'b1;
    #1;
    check("mid_idle_stall", StallM, 1'b1);
    @(negedge CLK);
    #1;
    check("mid_req_valid", MemReqValid, 1'b1);
    @(negedge CLK);
    #1;
    check("mid_wait_stall", StallM, 1'b1);
    check("mid_wait_valid", MemReqValid, 1'b0);
    RST_N = 1'b0;
    #1;
    check("mid_rst_stall", StallM, 1'b0);
    check("mid_rst_valid", MemReqValid, 1'b0);
    check("mid_rst_rdata", ReadDataM, 32'h0);
    check("mid_rst_addr", MemReqAddr, 32'h0);
    MemToRegM   = 1'b0;
    MemReqReady = 1'b0;
    @(negedge CLK);
    RST_N       = 1'b1;
    MemRspValid = 1'b1;
    MemRspRData = 32'hFEED_FACE;
    @(negedge CLK);
    MemRspValid = 1'b0;
    #1;
    check("post_rst_rdata", ReadDataM, 32'h0);
    check("post_rst_stall", StallM, 1'b0);
    check("post_rst_err", MemErrM, 1'b0);
    $display("reset mid-access: rdata=%h stall=%0b", ReadDataM, StallM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage consumer of the EX/MEM pipeline register outputs (MemWriteM, MemToRegM, ALUOutM, WriteDataM). Turns each load/store into a valid/ready request to a multi-cycle data memory, waits for the read response, and holds the pipeline with StallM until the access completes. Delivers the registered load result to the MEM/WB register and flags accesses that time out.

Parameters:
SIZE, 32, data and address width in bits
TIMEOUT, 255, max cycles spent in REQ+WAIT_RSP before abort (1..2^16-1)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
MemWriteM  input  1  store in MEM stage
MemToRegM  input  1  load in MEM stage
ALUOutM  input  SIZE  byte address of access
WriteDataM  input  SIZE  store data
StallM  output  1  freeze PC and all pipeline registers up to and including EX/MEM
ReadDataM  output  SIZE  registered load result
MemErrM  output  1  one-cycle pulse: access aborted by timeout
MemReqValid  output  1  request valid to data memory
MemReqReady  input  1  memory accepts request
MemReqWe  output  1  1 = write, 0 = read
MemReqAddr  output  SIZE  word address, bits [1:0] forced to 0
MemReqWData  output  SIZE  write data
MemRspValid  input  1  read data valid, one-cycle pulse
MemRspRData  input  SIZE  read data

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, timeout counter 0, ReadDataM 0, MemErrM 0, MemReqValid 0, MemReqWe 0, MemReqAddr 0, MemReqWData 0. StallM is 0 whenever no access is present.
- Access present = MemWriteM | MemToRegM. If both are set, the access is a write; the load is dropped and ReadDataM is unchanged.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: if an access is present, StallM=1 (combinational). On the edge, latch We=MemWriteM, Addr={ALUOutM[SIZE-1:2],2'b00} and WData=WriteDataM, clear the counter, and go to REQ. Otherwise StallM=0 and stay in IDLE.
- REQ: MemReqValid=1 and StallM=1. We, Addr and WData are stable until the handshake. Handshake = MemReqValid & MemReqReady on an edge.
  - Write: posted; go to DONE.
  - Read: go to WAIT_RSP.
- WAIT_RSP: MemReqValid=0 and StallM=1. On MemRspValid, ReadDataM<=MemRspRData and go to DONE. A MemRspValid in any other state is ignored.
- Timeout: the counter increments each cycle in REQ or WAIT_RSP. When it reaches TIMEOUT without completion:
  - go to DONE and set an error flag;
  - MemReqValid drops (abort);
  - for a read, ReadDataM<=0.
- DONE: StallM=0 for exactly one cycle so the pipeline advances. MemErrM=1 in this cycle only if the error flag is set. Always return to IDLE; inputs seen in DONE are the already-completed access and are never re-issued.
- ReadDataM holds its value until the next completed or aborted read.
- Latency (ready=1, response one cycle after handshake): load detected at cycle 0, StallM high for cycles 0-2, ReadDataM valid and StallM low in cycle 3. Store with ready=1: StallM high for cycles 0-1, low in cycle 2.
- Reset mid-access: immediate return to IDLE with all outputs at reset values. Any response still in flight is ignored.
- Address bits [1:0] are silently discarded; no misalignment trap.

Test Plan:
- Load, addr 0x0000_0104, MemReqReady=1, MemRspValid one cycle after the handshake with 0xDEAD_BEEF -> MemReqAddr=0x104, MemReqWe=0, StallM high 3 cycles, ReadDataM=0xDEADBEEF in cycle 3, MemErrM=0.
- Store, addr 0x0000_0020, data 0x1234_5678, MemReqReady low for 4 cycles then high -> MemReqValid held 5 cycles with stable addr/data/We=1, StallM high 6 cycles, exactly one handshake, ReadDataM unchanged.
- Load, TIMEOUT=8, memory never responds -> StallM high until timeout, MemErrM pulses 1 cycle in DONE, ReadDataM=0, a late MemRspValid afterwards is ignored.
- Back-to-back load then store with no bubble -> two separate handshakes, exactly one DONE cycle between them, no duplicate request for either instruction.
- MemWriteM=MemToRegM=1, addr 0x0000_0047 -> write issued to addr 0x44, ReadDataM unchanged.
- RST_N asserted while in WAIT_RSP -> same-cycle StallM=0 and MemReqValid=0, state IDLE; the following response pulse is ignored and ReadDataM=0.
